// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Deserializer for the registered serial stream of an upstream flip-flop.
//   Collects WIDTH bits, one per Shift strobe, into a parallel word. Q is
//   updated and Valid pulses for one cycle when a word completes.
//   Optional feature macro: PARITY_CHECK_EN. When defined, every word is
//   followed by an even-parity bit, and ParErr reports its check.
module serial_to_parallel #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             D,
  input  logic             Shift,
  input  logic             Clear,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Busy,
  output logic [CW-1:0]    BitCnt
`ifdef PARITY_CHECK_EN
  ,
  output logic             ParErr
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_shifted;

`ifdef PARITY_CHECK_EN
  logic r_parerr;
  logic w_parerr_nxt;
`endif

  // The register contents after accepting D, in the configured bit order.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], D}
                               : {D, r_shreg[WIDTH-1:1]};

  // Next-state and next-output decode: Clear wins over Shift; Shift=0 holds.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_q_nxt      = r_q;
    w_valid_nxt  = 1'b0;
`ifdef PARITY_CHECK_EN
    w_parerr_nxt = r_parerr;
`endif
    if (Clear) begin
      w_state_nxt  = COLLECT;
      w_shreg_nxt  = '0;
      w_bitcnt_nxt = '0;
    end else if (Shift) begin
      case (r_state)
        COLLECT: begin
          w_shreg_nxt = w_shifted;
          if (r_bitcnt == LAST_BIT) begin
            w_bitcnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            // Word is complete but stays internal until its parity bit arrives.
            w_state_nxt  = PARITY;
`else
            w_q_nxt      = w_shifted;
            w_valid_nxt  = 1'b1;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
        default: begin
`ifdef PARITY_CHECK_EN
          // D is the even-parity bit: a correct word plus parity has zero XOR.
          w_q_nxt      = r_shreg;
          w_valid_nxt  = 1'b1;
          w_parerr_nxt = (^r_shreg) ^ D;
          w_state_nxt  = COLLECT;
`endif
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= COLLECT;
      // NOTE: the shift register is reset too, so a word started after reset never carries stale bits.
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_q      <= '0;
      r_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values.
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_q      <= w_q_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error flag, registered with Valid and held until the next word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_parerr <= 1'b0;
    end else begin
      r_parerr <= w_parerr_nxt;
    end
  end

  assign ParErr = r_parerr;
`endif

  assign Q      = r_q;
  assign Valid  = r_valid;
  assign BitCnt = r_bitcnt;
  assign Busy   = (r_bitcnt != '0) || (r_state == PARITY);

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel
//   Drives one serial stream into an MSB-first and an LSB-first instance.
//   Expected words are queued when a word's final bit is driven, and they are
//   popped and compared whenever an instance raises Valid.
//   Honors PARITY_CHECK_EN the same way the design does.
module tb_serial_to_parallel;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef PARITY_CHECK_EN
  localparam int WORD_CYC = W + 1;
`else
  localparam int WORD_CYC = W;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          D = 1'b0;
  logic          Shift = 1'b0;
  logic          Clear = 1'b0;
  logic [W-1:0]  q_msb, q_lsb;
  logic          v_msb, v_lsb;
  logic          b_msb, b_lsb;
  logic [CW-1:0] c_msb, c_lsb;
`ifdef PARITY_CHECK_EN
  logic          pe_msb, pe_lsb;
  logic          exp_pe[$];
`endif

  logic [W-1:0]  exp_msb[$];
  logic [W-1:0]  exp_lsb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc = 0;
  int            prev_valid = 0;
  int            last_valid = 0;

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk(Clk), .Reset(Reset), .D(D), .Shift(Shift), .Clear(Clear),
    .Q(q_msb), .Valid(v_msb), .Busy(b_msb), .BitCnt(c_msb)
`ifdef PARITY_CHECK_EN
    , .ParErr(pe_msb)
`endif
  );

  serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk(Clk), .Reset(Reset), .D(D), .Shift(Shift), .Clear(Clear),
    .Q(q_lsb), .Valid(v_lsb), .Busy(b_lsb), .BitCnt(c_lsb)
`ifdef PARITY_CHECK_EN
    , .ParErr(pe_lsb)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The LSB-first instance sees the same stream, so its word is bit-reversed.
  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  // Scoreboard monitor: sample on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    cyc++;
    if (v_msb) begin
      prev_valid = last_valid;
      last_valid = cyc;
      if (exp_msb.size() == 0) check("msb_spurious_valid", 32'd1, 32'd0);
      else begin
        check("msb_q", 32'(q_msb), 32'(exp_msb.pop_front()));
`ifdef PARITY_CHECK_EN
        if (exp_pe.size() == 0) check("perr_spurious", 32'd1, 32'd0);
        else begin
          logic e;
          e = exp_pe.pop_front();
          check("msb_parerr", 32'(pe_msb), 32'(e));
          check("lsb_parerr", 32'(pe_lsb), 32'(e));
        end
`endif
      end
    end
    if (v_lsb) begin
      if (exp_lsb.size() == 0) check("lsb_spurious_valid", 32'd1, 32'd0);
      else check("lsb_q", 32'(q_lsb), 32'(exp_lsb.pop_front()));
    end
  end

  // One bit accepted on the next rising edge; returns #1 after that edge.
  task automatic send_bit(input logic b);
    Shift = 1'b1;
    D     = b;
    @(posedge Clk);
    #1;
    Shift = 1'b0;
  endtask

  task automatic idle(input int n);
    Shift = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Sends w MSB-first with `gap` idle cycles between bits; perr_flip inverts the parity bit.
  task automatic send_word(input logic [W-1:0] w, input int gap, input logic perr_flip);
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) begin
        exp_msb.push_back(w);
        exp_lsb.push_back(rev(w));
`ifdef PARITY_CHECK_EN
        exp_pe.push_back(perr_flip);
`endif
      end
      send_bit(w[i]);
      if (i != 0 && gap > 0) idle(gap);
    end
`ifdef PARITY_CHECK_EN
    check("parity_state_busy", 32'(b_msb), 32'd1);
    check("parity_state_cnt", 32'(c_msb), 32'd0);
    send_bit((^w) ^ perr_flip);
`else
    if (perr_flip) check("perr_flip_unused", 32'(perr_flip), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, checked before any clock edge.
    #1 Reset = 1'b1;
    #1;
    check("rst_q", 32'(q_msb), 32'd0);
    check("rst_valid", 32'(v_msb), 32'd0);
    check("rst_busy", 32'(b_msb), 32'd0);
    check("rst_bitcnt", 32'(c_msb), 32'd0);
    check("rst_q_lsb", 32'(q_lsb), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    idle(2);

    // Bits 1,1,0,1,0,0,0,0: D0 MSB-first, 0B LSB-first.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("mid_bitcnt", 32'(c_msb), 32'd3);
    check("mid_busy", 32'(b_msb), 32'd1);
    check("mid_q_held", 32'(q_msb), 32'd0);
    exp_msb.push_back(8'hD0);
    exp_lsb.push_back(8'h0B);
`ifdef PARITY_CHECK_EN
    exp_pe.push_back(1'b0);
`endif
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    idle(3);
    check("t1_drained", 32'(exp_msb.size() + exp_lsb.size()), 32'd0);
    check("t1_q_hold", 32'(q_msb), 32'hD0);
    check("t1_valid_low", 32'(v_msb), 32'd0);

    // Back-to-back words: Valid pulses exactly one word period apart.
    send_word(8'h12, 0, 1'b0);
    send_word(8'h34, 0, 1'b0);
    idle(3);
    check("b2b_spacing", 32'(last_valid - prev_valid), 32'(WORD_CYC));
    check("b2b_q_hold", 32'(q_msb), 32'h34);
    check("b2b_busy", 32'(b_msb), 32'd0);

    // 3 bits, then Clear with Shift on the same edge, then 8 ones with gaps.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    Clear = 1'b1;
    send_bit(1'b1);
    Clear = 1'b0;
    check("clr_bitcnt", 32'(c_msb), 32'd0);
    check("clr_busy", 32'(b_msb), 32'd0);
    check("clr_q_kept", 32'(q_msb), 32'h34);
    idle(1);
    check("clr_no_valid", 32'(v_msb), 32'd0);
    send_word(8'hFF, 1, 1'b0);
    idle(3);
    check("clr_word", 32'(q_msb), 32'hFF);

    // Reset between edges after 5 bits, then a fresh word.
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    #1 Reset = 1'b1;
    #1;
    check("arst_q", 32'(q_msb), 32'd0);
    check("arst_valid", 32'(v_msb), 32'd0);
    check("arst_busy", 32'(b_msb), 32'd0);
    check("arst_bitcnt", 32'(c_msb), 32'd0);
    #1 Reset = 1'b0;
    send_word(8'h5A, 0, 1'b0);
    idle(3);
    check("arst_word", 32'(q_msb), 32'h5A);

    // Random words with random bit gaps.
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      send_word(w, int'($urandom_range(0, 2)), 1'b0);
    end
    idle(3);

`ifdef PARITY_CHECK_EN
    // A5 has even weight: parity bit 0 is clean, parity bit 1 is an error.
    send_word(8'hA5, 0, 1'b0);
    idle(2);
    send_word(8'hA5, 0, 1'b1);
    idle(3);
    check("parerr_held", 32'(pe_msb), 32'd1);
`endif

    check("sb_drain", 32'(exp_msb.size() + exp_lsb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
